dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, waits a programmable number of cycles, performs the byte/halfword/word access, and returns load data or a status over a second valid/ready handshake. It sits between the datapath's load/store unit (the initiator) and a word-organised storage array, and replaces the zero-latency data memory when the pipeline is made stall-aware.

## Interface
- N, 32, data and address width
- AW, 10, byte-address bits actually decoded; storage is 2^(AW-2) words of N bits
- LAT, 2, wait cycles between request acceptance and access (0 allowed)

Ports:
- clk  in  1  rising-edge clock; the block has one clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store
- req_addr  in  N  byte address
- req_wdata  in  N  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  N  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3

## Operation
- FSM states IDLE, WAIT, RESP. Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/funct3/addr/wdata; go to WAIT with counter=LAT, or straight to access if LAT=0.
- WAIT: req_ready=0; counter decrements each cycle; at 0 the access executes on that edge and the state becomes RESP.
- Access: word index = addr[AW-1:2]; addr[N-1:AW] ignored (aliases). Loads: LB(000)/LBU(100) select byte addr[1:0], LH(001)/LHU(101) halfword addr[1], LW(010) full word; sign- or zero-extend to N. Stores: SB(000)/SH(001)/SW(010) write only the addressed byte lanes from the low bytes of wdata; other lanes unchanged.
- Error: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, any other funct3 (store with 1xx, load with 011/11x) -> rsp_err=1, rsp_rdata=0, no write.
- RESP: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready; then IDLE, rsp_valid=0. req_ready stays 0 during RESP (no overlap of request and response).
- Storage contents are not reset; reset mid-operation drops any pending request with no write. A store that already executed remains committed.

## Timing
- Request accepted at edge k -> access at edge k+LAT+1 -> rsp_valid high from that edge.
- rsp_ready held high: response handshake at edge k+LAT+2; next request accepted no earlier than edge k+LAT+3 (req_ready re-asserts after the response handshake edge).
- Store data visible to any load accepted after the store's response handshake.
- req_* inputs ignored outside the IDLE handshake; changing them during WAIT has no effect.
- rst asserts asynchronously at any point: outputs take reset values immediately, independent of clk.

## Structure
- Package dmem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, a misalign-check function.
- One sub-module, dmem_bytelane: combinational load extraction/extension and store byte-mask/merge from funct3 and addr[1:0]; the FSM, counter and storage array stay in dmem_responder.

## Test plan
- Reset then SW 0xDEADBEEF @0x010, LW @0x010 (LAT=2) -> rsp_valid 3 edges after each acceptance, rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x013 over that word, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF.
- LH @0x011 and SW @0x012 -> err=1, rdata=0; subsequent LW @0x010 unchanged; funct3=011 load -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_rdata/rsp_err stable, req_ready=0, new req_valid ignored until handshake.
- Assert rst during WAIT of SW 0x12345678 @0x020 (word preloaded 0x0) -> rsp_valid never rises, req_ready=1 immediately, LW @0x020 returns 0x0.
- LAT=0 build: LW accepted at edge k -> rsp_valid at edge k+1; address 0x410 with AW=10 aliases 0x010.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM
// encoding and the access legality check.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Unsigned encodings exist only for loads; everything else is illegal.
   function automatic logic access_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
      logic err;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_H:    err = off[0];
         F3_W:    err = (off != 2'b00);
         F3_BU:   err = we;
         F3_HU:   err = we | off[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// Byte-lane steering for one word: load extraction/extension and
// store lane merge, driven by funct3 and the low address bits.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [2:0]   funct3,
   input  logic [1:0]   off,
   input  logic [N-1:0] rword,
   input  logic [N-1:0] wdata,
   output logic [N-1:0] load_data,
   output logic [N-1:0] wword
);

   localparam int NB = N / 8;

   logic [7:0]    byte_s;
   logic [15:0]   half_s;
   logic [NB-1:0] wmask_s;
   logic [N-1:0]  lanes_s;

   assign byte_s = rword[{off, 3'b000} +: 8];
   assign half_s = rword[{off[1], 4'b0000} +: 16];

   // Load result, sign- or zero-extended to the full word.
   always_comb begin
      load_data = {N{1'b0}};
      case (funct3)
         F3_B:    load_data = {{(N-8){byte_s[7]}}, byte_s};
         F3_BU:   load_data = {{(N-8){1'b0}}, byte_s};
         F3_H:    load_data = {{(N-16){half_s[15]}}, half_s};
         F3_HU:   load_data = {{(N-16){1'b0}}, half_s};
         F3_W:    load_data = rword;
         default: load_data = {N{1'b0}};
      endcase
   end

   // Store data is replicated across lanes so the mask alone selects placement.
   always_comb begin
      wmask_s = {NB{1'b0}};
      lanes_s = wdata;
      case (funct3)
         F3_B: begin
            wmask_s = NB'(1'b1) << off;
            lanes_s = {NB{wdata[7:0]}};
         end
         F3_H: begin
            wmask_s = NB'(2'b11) << {off[1], 1'b0};
            lanes_s = {(NB/2){wdata[15:0]}};
         end
         F3_W: begin
            wmask_s = {NB{1'b1}};
            lanes_s = wdata;
         end
         default: begin
            wmask_s = {NB{1'b0}};
            lanes_s = wdata;
         end
      endcase
   end

   // Merge: masked lanes take new data, the rest keep the stored word.
   always_comb begin
      wword = rword;
      for (int i = 0; i < NB; i++) begin
         if (wmask_s[i]) begin
            wword[i*8 +: 8] = lanes_s[i*8 +: 8];
         end else begin
            wword[i*8 +: 8] = rword[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Latency-programmable data-memory responder: one outstanding load/store,
// request and response each over a valid/ready handshake.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int N   = 32,
   parameter int AW  = 10,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [2:0]   req_funct3,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_rdata,
   output logic         rsp_err
);

   localparam int WORDS = 2 ** (AW - 2);
   localparam int CW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [CW-1:0] LAT_C = CW'(LAT);

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic            we_r;
   logic [2:0]      funct3_r;
   logic [AW-1:0]   addr_r;
   logic [N-1:0]    wdata_r;

   logic [N-1:0]    mem_r [WORDS];

   logic [AW-3:0]   idx_s;
   logic [N-1:0]    rword_s;
   logic [N-1:0]    load_s;
   logic [N-1:0]    wword_s;
   logic            err_s;
   logic            fire_s;
   logic            mem_we_s;
   logic            addr_unused_s;

   // Upper address bits alias onto the decoded range by design.
   assign addr_unused_s = ^req_addr[N-1:AW];

   assign idx_s    = addr_r[AW-1:2];
   assign rword_s  = mem_r[idx_s];
   assign err_s    = access_err(we_r, funct3_r, addr_r[1:0]);
   assign fire_s   = (state_r == ST_WAIT) && (cnt_r == {CW{1'b0}});
   assign mem_we_s = fire_s && we_r && !err_s;

   dmem_bytelane #(.N(N)) u_bytelane (
      .funct3    (funct3_r),
      .off       (addr_r[1:0]),
      .rword     (rword_s),
      .wdata     (wdata_r),
      .load_data (load_s),
      .wword     (wword_s)
   );

   // Storage array: no reset, written only on the access edge of a legal store.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[idx_s] <= wword_s;
      end
   end

   // Request/wait/response sequencing with registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         we_r      <= 1'b0;
         funct3_r  <= 3'b000;
         addr_r    <= {AW{1'b0}};
         wdata_r   <= {N{1'b0}};
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= {N{1'b0}};
         rsp_err   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  we_r      <= req_we;
                  funct3_r  <= req_funct3;
                  addr_r    <= req_addr[AW-1:0];
                  wdata_r   <= req_wdata;
                  cnt_r     <= LAT_C;
                  req_ready <= 1'b0;
                  state_r   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // With LAT=0 the counter is already zero, so this is the access edge.
               if (cnt_r == {CW{1'b0}}) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= err_s;
                  rsp_rdata <= (err_s || we_r) ? {N{1'b0}} : load_s;
                  state_r   <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
